// File: rtl/if_stage_buffered_if.sv
// rtl/if_stage_buffered_if.sv - fetch-to-decode handshake bundle (head of the fetch queue)
interface if_stage_buffered_if #(
   parameter int PC_WIDTH = 32
) ();
   logic                out_valid;
   logic                out_ready;
   logic [PC_WIDTH-1:0] out_pc;
   logic [PC_WIDTH-1:0] out_pc_4;
   logic [31:0]         out_instr;

   modport master (output out_valid, out_pc, out_pc_4, out_instr, input out_ready);
   modport slave  (input out_valid, out_pc, out_pc_4, out_instr, output out_ready);
endinterface

// File: rtl/if_stage_buffered.sv
// rtl/if_stage_buffered.sv - buffered fetch stage: PC, sync-read imem request, fetch queue to decode
// Optional perf counters (stall cycles, flushes) enabled by defining IF_PERF_CNT_EN.
module if_stage_buffered #(
   parameter int                  PC_WIDTH   = 32,
   parameter int                  IMEM_AW    = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
   parameter int                  FIFO_DEPTH = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   output logic                imem_en,
   output logic [IMEM_AW-1:0]  imem_addr,
   input  logic [31:0]         imem_rdata,
`ifdef IF_PERF_CNT_EN
   output logic [31:0]         perf_stall_cycles,
   output logic [31:0]         perf_flush_count,
`endif
   if_stage_buffered_if.master out_if
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] tag_q, tag_d;
   logic                inflight_q, inflight_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PC_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
   logic [PC_WIDTH-1:0] fifo_pc_d    [FIFO_DEPTH];
   logic [31:0]         fifo_instr_q [FIFO_DEPTH];
   logic [31:0]         fifo_instr_d [FIFO_DEPTH];

   logic                head_valid;
   logic                pop;
   logic                push;
   logic                issue;
   logic [OCC_W-1:0]    occupancy;
   logic [PC_WIDTH-1:0] head_pc;

   always_comb begin
      head_valid = (count_q != '0);
      pop        = head_valid & out_if.out_ready & ~redirect_valid;
      push       = inflight_q & ~redirect_valid;
      // Reserve a slot for the word already in flight so a response is never dropped.
      occupancy  = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
      issue      = ~redirect_valid & (occupancy < OCC_W'(FIFO_DEPTH));
   end

   always_comb begin
      pc_d         = pc_q;
      tag_d        = tag_q;
      inflight_d   = issue;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      fifo_pc_d    = fifo_pc_q;
      fifo_instr_d = fifo_instr_q;
      count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
      if (issue) begin
         tag_d = pc_q;
         pc_d  = pc_q + PC_WIDTH'(4);
      end
      if (push) begin
         fifo_pc_d[wr_ptr_q]    = tag_q;
         fifo_instr_d[wr_ptr_q] = imem_rdata;
         wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (redirect_valid) begin
         pc_d       = redirect_pc & ~PC_WIDTH'(3);
         inflight_d = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         tag_q      <= '0;
         inflight_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc_q[i]    <= '0;
            fifo_instr_q[i] <= '0;
         end
      end else begin
         pc_q         <= pc_d;
         tag_q        <= tag_d;
         inflight_q   <= inflight_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         fifo_pc_q    <= fifo_pc_d;
         fifo_instr_q <= fifo_instr_d;
      end
   end

   assign imem_en   = issue;
   assign imem_addr = pc_q[IMEM_AW+1:2];

   assign head_pc          = head_valid ? fifo_pc_q[rd_ptr_q] : '0;
   assign out_if.out_valid = head_valid;
   assign out_if.out_pc    = head_pc;
   assign out_if.out_pc_4  = head_valid ? head_pc + PC_WIDTH'(4) : '0;
   assign out_if.out_instr = head_valid ? fifo_instr_q[rd_ptr_q] : '0;

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (head_valid && !out_if.out_ready && stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (redirect_valid && flush_cnt_q != '1) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cycles = stall_cnt_q;
   assign perf_flush_count  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_stage_buffered.sv
// tb/tb_if_stage_buffered.sv - scoreboard bench for if_stage_buffered (32-bit and 8-bit PC instances)
module tb_if_stage_buffered;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_en;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata = '0;

   logic        redirect_valid8 = 1'b0;
   logic [7:0]  redirect_pc8 = '0;
   logic        imem_en8;
   logic [5:0]  imem_addr8;
   logic [31:0] imem_rdata8 = '0;

   if_stage_buffered_if #(.PC_WIDTH(32)) ifm ();
   if_stage_buffered_if #(.PC_WIDTH(8))  if8 ();

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt, stall_cnt8, flush_cnt8;
`endif

   if_stage_buffered #(.PC_WIDTH(32), .IMEM_AW(8), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
`ifdef IF_PERF_CNT_EN
      .perf_stall_cycles(stall_cnt), .perf_flush_count(flush_cnt),
`endif
      .out_if(ifm)
   );

   if_stage_buffered #(.PC_WIDTH(8), .IMEM_AW(6), .RESET_PC(8'hF8), .FIFO_DEPTH(4)) dut8 (
      .clock(clock), .reset(reset),
      .redirect_valid(redirect_valid8), .redirect_pc(redirect_pc8),
      .imem_en(imem_en8), .imem_addr(imem_addr8), .imem_rdata(imem_rdata8),
`ifdef IF_PERF_CNT_EN
      .perf_stall_cycles(stall_cnt8), .perf_flush_count(flush_cnt8),
`endif
      .out_if(if8)
   );

   always @(posedge clock) begin
      if (imem_en)  imem_rdata  <= 32'h1000_0000 + {24'h0, imem_addr};
      if (imem_en8) imem_rdata8 <= 32'h1000_0000 + {26'h0, imem_addr8};
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc_4;
      logic [31:0] instr;
   } exp_t;

   exp_t sb[$];
   exp_t sb8[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.pc_4  = pc + 32'd4;
      e.instr = 32'h1000_0000 + ((pc >> 2) & 32'hFF);
      return e;
   endfunction

   task automatic expect_run(input logic [31:0] first, input int n);
      for (int i = 0; i < n; i++) sb.push_back(mk(first + 32'(4 * i)));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      if (reset && ifm.out_valid && ifm.out_ready && !redirect_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_accept_pc", {32'h0, ifm.out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("accept_pc",    {32'h0, ifm.out_pc},    {32'h0, e.pc});
            check("accept_pc_4",  {32'h0, ifm.out_pc_4},  {32'h0, e.pc_4});
            check("accept_instr", {32'h0, ifm.out_instr}, {32'h0, e.instr});
         end
      end
      if (reset && if8.out_valid && if8.out_ready && sb8.size() != 0) begin
         exp_t e;
         e = sb8.pop_front();
         check("pc8_out_pc",    {56'h0, if8.out_pc},   {32'h0, e.pc});
         check("pc8_out_pc_4",  {56'h0, if8.out_pc_4}, {32'h0, e.pc_4});
         check("pc8_out_instr", {32'h0, if8.out_instr}, {32'h0, e.instr});
      end
   end

   initial begin
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ifm.out_ready  = 1'b0;
      if8.out_ready  = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("reset_out_valid", {63'h0, ifm.out_valid}, 64'h0);
      check("reset_out_pc",    {32'h0, ifm.out_pc},    64'h0);
      check("reset_out_pc_4",  {32'h0, ifm.out_pc_4},  64'h0);
      check("reset_out_instr", {32'h0, ifm.out_instr}, 64'h0);
`ifdef IF_PERF_CNT_EN
      check("reset_perf_stall", {32'h0, stall_cnt}, 64'h0);
      check("reset_perf_flush", {32'h0, flush_cnt}, 64'h0);
`endif

      expect_run(32'h0, 6);
      sb8.push_back('{pc: 32'hF8, pc_4: 32'hFC, instr: 32'h1000_003E});
      sb8.push_back('{pc: 32'hFC, pc_4: 32'h00, instr: 32'h1000_003F});
      sb8.push_back('{pc: 32'h00, pc_4: 32'h04, instr: 32'h1000_0000});
      sb8.push_back('{pc: 32'h04, pc_4: 32'h08, instr: 32'h1000_0001});
      ifm.out_ready = 1'b1;

      step(); reset = 1'b1;                                  // cycle 0
      @(negedge clock);
      check("first_imem_en",   {63'h0, imem_en},       64'h1);
      check("first_imem_addr", {56'h0, imem_addr},     64'h0);
      check("c0_out_valid",    {63'h0, ifm.out_valid}, 64'h0);
      step();                                                // cycle 1
      @(negedge clock);
      check("c1_out_valid", {63'h0, ifm.out_valid}, 64'h0);
      step();                                                // cycle 2
      @(negedge clock);
      check("c2_out_valid", {63'h0, ifm.out_valid}, 64'h1);
      check("c2_out_pc",    {32'h0, ifm.out_pc},    64'h0);
      check("c2_out_instr", {32'h0, ifm.out_instr}, 64'h1000_0000);

      repeat (6) step();                                     // cycle 8
      ifm.out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin                     // cycles 8..17
         @(negedge clock);
         check("stall_out_valid", {63'h0, ifm.out_valid}, 64'h1);
         check("stall_head_pc",   {32'h0, ifm.out_pc},    64'd24);
         if (i >= 2) check("stall_imem_en", {63'h0, imem_en}, 64'h0);
         step();
      end
      expect_run(32'd24, 2);                                 // cycle 18
      ifm.out_ready = 1'b1;
      step();                                                // cycle 19
      step();                                                // cycle 20
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      @(negedge clock);
      check("redir_imem_en",   {63'h0, imem_en},       64'h0);
      check("redir_out_valid", {63'h0, ifm.out_valid}, 64'h1);
      step();                                                // cycle 21
      redirect_valid = 1'b0;
      expect_run(32'h100, 3);
      @(negedge clock);
      check("post_redir_valid", {63'h0, ifm.out_valid}, 64'h0);
      check("post_redir_en",    {63'h0, imem_en},       64'h1);
      check("post_redir_addr",  {56'h0, imem_addr},     64'h40);
      step();                                                // cycle 22
      @(negedge clock);
      check("c22_out_valid", {63'h0, ifm.out_valid}, 64'h0);
      step();                                                // cycle 23
      @(negedge clock);
      check("c23_out_valid", {63'h0, ifm.out_valid}, 64'h1);
      check("c23_out_pc",    {32'h0, ifm.out_pc},    64'h100);

      repeat (3) step();                                     // cycle 26
      redirect_valid = 1'b1;
      redirect_pc    = 32'h2000_0007;
      step();                                                // cycle 27
      redirect_pc    = 32'h0000_0202;
      @(negedge clock);
      check("b2b_out_valid", {63'h0, ifm.out_valid}, 64'h0);
      step();                                                // cycle 28
      redirect_valid = 1'b0;
      expect_run(32'h200, 4);
      @(negedge clock);
      check("b2b_imem_en",   {63'h0, imem_en},   64'h1);
      check("b2b_imem_addr", {56'h0, imem_addr}, 64'h80);
      step();                                                // cycle 29
      @(negedge clock);
      check("c29_out_valid", {63'h0, ifm.out_valid}, 64'h0);

      repeat (5) step();                                     // cycle 34
      ifm.out_ready = 1'b0;
      repeat (3) step();                                     // cycle 37, queue full
      check("full_imem_en", {63'h0, imem_en},    64'h0);
      check("full_head_pc", {32'h0, ifm.out_pc}, 64'h210);
`ifdef IF_PERF_CNT_EN
      check("perf_stall_cycles", {32'h0, stall_cnt}, 64'd13);
      check("perf_flush_count",  {32'h0, flush_cnt}, 64'd3);
`endif
      reset = 1'b0;
      #2;
      check("async_rst_valid", {63'h0, ifm.out_valid}, 64'h0);
      check("async_rst_pc",    {32'h0, ifm.out_pc},    64'h0);
`ifdef IF_PERF_CNT_EN
      check("rst_perf_stall", {32'h0, stall_cnt}, 64'h0);
      check("rst_perf_flush", {32'h0, flush_cnt}, 64'h0);
`endif
      expect_run(32'h0, 5);
      ifm.out_ready = 1'b1;
      step();
      step(); reset = 1'b1;                                  // R0
      @(negedge clock);
      check("restart_imem_en",   {63'h0, imem_en},   64'h1);
      check("restart_imem_addr", {56'h0, imem_addr}, 64'h0);
      check("restart_valid",     {63'h0, ifm.out_valid}, 64'h0);
      step();                                                // R1
      step();                                                // R2
      @(negedge clock);
      check("restart_out_valid", {63'h0, ifm.out_valid}, 64'h1);
      check("restart_out_pc",    {32'h0, ifm.out_pc},    64'h0);
      repeat (5) step();                                     // R7
      ifm.out_ready = 1'b0;
      @(negedge clock);
      step();

      check("sb_drained",  64'(sb.size()),  64'h0);
      check("sb8_drained", 64'(sb8.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
